// File: rtl/hamming_decoder.sv
// Serial extended-Hamming (SECDED) decoder: receives a 2^R-bit codeword one bit per cycle,
// corrects single errors, flags double errors and shifts out the data bits serially.
module hamming_decoder #(
  parameter int unsigned R = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic datain,
  input  logic din_valid,
  output logic ready,
  output logic dataout,
  output logic dout_valid,
  output logic err_single,
  output logic err_double,
  output logic frame_done
);

  localparam int unsigned N = 1 << R;
  localparam int unsigned K = N - R - 1;

  typedef enum logic [1:0] {StRecv, StCheck, StSend} state_e;

  state_e         state_q, state_d;
  logic [R-1:0]   cnt_q, cnt_d;
  logic [N-1:0]   frame_q, frame_d;
  logic [K-1:0]   data_q, data_d;
  logic           err_single_q, err_single_d;
  logic           err_double_q, err_double_d;

  logic [R-1:0]   syn;
  logic           parity;
  logic [N-1:0]   corrected;

  // Gather the non-power-of-two positions, ascending, into d0..d(K-1).
  function automatic logic [K-1:0] extract_data(input logic [N-1:0] cw);
    logic [K-1:0] d;
    int           j;
    d = '0;
    j = 0;
    for (int i = 1; i < N; i++) begin
      if ((i & (i - 1)) != 0) begin
        d[j] = cw[i];
        j++;
      end
    end
    return d;
  endfunction

  always_comb begin
    syn = '0;
    for (int i = 0; i < N; i++) begin
      if (frame_q[i]) syn ^= R'(i);
    end
  end

  assign parity    = ^frame_q;
  // Odd overall parity means exactly one flipped bit, located by the syndrome.
  assign corrected = parity ? (frame_q ^ (N'(1) << syn)) : frame_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    frame_d      = frame_q;
    data_d       = data_q;
    err_single_d = err_single_q;
    err_double_d = err_double_q;
    unique case (state_q)
      StRecv: begin
        if (din_valid) begin
          frame_d[cnt_q] = datain;
          cnt_d          = cnt_q + 1'b1;
          if (cnt_q == R'(N - 1)) state_d = StCheck;
        end
      end
      StCheck: begin
        frame_d      = corrected;
        data_d       = extract_data(corrected);
        err_single_d = parity;
        err_double_d = !parity && (syn != '0);
        cnt_d        = '0;
        state_d      = StSend;
      end
      StSend: begin
        data_d = data_q >> 1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == R'(K - 1)) begin
          cnt_d   = '0;
          state_d = StRecv;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = StRecv;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRecv;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      frame_q      <= '0;
      data_q       <= '0;
      err_single_q <= 1'b0;
      err_double_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      frame_q      <= frame_d;
      data_q       <= data_d;
      err_single_q <= err_single_d;
      err_double_q <= err_double_d;
    end
  end

  assign ready      = (state_q == StRecv);
  assign dout_valid = (state_q == StSend);
  assign dataout    = dout_valid & data_q[0];
  assign frame_done = dout_valid && (cnt_q == '0);
  assign err_single = err_single_q;
  assign err_double = err_double_q;

endmodule

// File: tb/tb_hamming_decoder.sv
// Self-checking bench for hamming_decoder: directed frame table, reset corner cases and
// random frames built by an independent encoder with injected errors.
module tb_hamming_decoder;

  localparam int R = 4;
  localparam int N = 16;
  localparam int K = 11;

  logic clk = 1'b0;
  logic rst_n;
  logic datain;
  logic din_valid;
  logic ready;
  logic dataout;
  logic dout_valid;
  logic err_single;
  logic err_double;
  logic frame_done;

  int total = 0;
  int bad   = 0;

  hamming_decoder #(.R(R)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .datain    (datain),
    .din_valid (din_valid),
    .ready     (ready),
    .dataout   (dataout),
    .dout_valid(dout_valid),
    .err_single(err_single),
    .err_double(err_double),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] cw;
    logic [10:0] data;
    logic        es;
    logic        ed;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] encode(input logic [10:0] d);
    logic [15:0] c;
    logic        p;
    int          j;
    c = '0;
    j = 0;
    for (int i = 1; i < N; i++) begin
      if ((i & (i - 1)) != 0) begin
        c[i] = d[j];
        j++;
      end
    end
    for (int k = 0; k < R; k++) begin
      p = 1'b0;
      for (int i = 1; i < N; i++) begin
        if (((i >> k) & 1) == 1 && (i & (i - 1)) != 0) p ^= c[i];
      end
      c[1 << k] = p;
    end
    c[0] = ^c[15:1];
    return c;
  endfunction

  function automatic logic [10:0] raw_data(input logic [15:0] c);
    logic [10:0] d;
    int          j;
    d = '0;
    j = 0;
    for (int i = 1; i < N; i++) begin
      if ((i & (i - 1)) != 0) begin
        d[j] = c[i];
        j++;
      end
    end
    return d;
  endfunction

  // Caller is at posedge+1; returns at posedge+1 after the last accepted bit.
  task automatic drive_bits(input logic [15:0] cw, input int n);
    for (int i = 0; i < n; i++) begin
      din_valid = 1'b1;
      datain    = cw[i];
      @(posedge clk);
      #1;
    end
    din_valid = 1'b0;
  endtask

  task automatic run_frame(input string tag, input logic [15:0] cw, input logic [10:0] exp_data,
                           input logic es, input logic ed, input int stall_at, input bit junk);
    logic [10:0] got;
    int          low;
    int          vbad;
    int          fbad;
    got  = '0;
    low  = 0;
    vbad = 0;
    fbad = 0;
    for (int i = 0; i < N; i++) begin
      if (i == stall_at) begin
        repeat (3) begin
          din_valid = 1'b0;
          datain    = 1'($urandom);
          @(posedge clk);
          #1;
        end
      end
      if (ready !== 1'b1) vbad++;
      din_valid = 1'b1;
      datain    = cw[i];
      @(posedge clk);
      #1;
    end
    din_valid = junk;
    datain    = 1'b1;
    if (ready !== 1'b1) low++;
    if (dout_valid !== 1'b0) vbad++;
    for (int k = 0; k < K; k++) begin
      @(posedge clk);
      #1;
      datain = 1'($urandom);
      if (ready !== 1'b1) low++;
      if (dout_valid !== 1'b1) vbad++;
      got[k] = dataout;
      if (frame_done !== (k == 0)) fbad++;
    end
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    check({tag, " data"}, 32'(got), 32'(exp_data));
    check({tag, " flags"}, {30'd0, err_single, err_double}, {30'd0, es, ed});
    check({tag, " ready_low_cycles"}, low, 12);
    check({tag, " handshake"}, vbad, 0);
    check({tag, " frame_done"}, fbad, 0);
    check({tag, " back_in_recv"}, {29'd0, ready, dout_valid, frame_done}, 32'b100);
  endtask

  initial begin
    logic [10:0] d;
    logic [15:0] cw;
    logic [10:0] exp_d;
    int          nerr;
    int          p1;
    int          p2;

    vecs[0] = '{cw: 16'h0069, data: 11'h007, es: 1'b0, ed: 1'b0};
    vecs[1] = '{cw: 16'h1069, data: 11'h007, es: 1'b1, ed: 1'b0};
    vecs[2] = '{cw: 16'h0068, data: 11'h007, es: 1'b1, ed: 1'b0};
    vecs[3] = '{cw: 16'h1269, data: 11'h097, es: 1'b0, ed: 1'b1};

    rst_n     = 1'b0;
    din_valid = 1'b0;
    datain    = 1'b0;
    #3;
    check("reset outputs", {26'd0, ready, dout_valid, dataout, err_single, err_double, frame_done},
          32'b100000);
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int v = 0; v < 4; v++) begin
      run_frame($sformatf("vec%0d", v), vecs[v].cw, vecs[v].data, vecs[v].es, vecs[v].ed, -1, 0);
    end

    // Stall after idx7 plus junk valid pulses during CHECK/SEND, then a normal frame.
    run_frame("stall_junk", vecs[0].cw, vecs[0].data, 1'b0, 1'b0, 8, 1);
    run_frame("after_junk", vecs[3].cw, vecs[3].data, 1'b0, 1'b1, -1, 0);

    // Asynchronous reset mid-RECV.
    drive_bits(vecs[0].cw, 8);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset mid_recv", {26'd0, ready, dout_valid, dataout, err_single, err_double,
          frame_done}, 32'b100000);
    #4;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_frame("post_reset_recv", vecs[0].cw, vecs[0].data, 1'b0, 1'b0, -1, 0);

    // Asynchronous reset mid-SEND while an error flag is held.
    drive_bits(vecs[1].cw, N);
    repeat (4) @(posedge clk);
    #1;
    check("mid_send state", {29'd0, dout_valid, err_single, ready}, 32'b110);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset mid_send", {26'd0, ready, dout_valid, dataout, err_single, err_double,
          frame_done}, 32'b100000);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_frame("post_reset_send", vecs[0].cw, vecs[0].data, 1'b0, 1'b0, -1, 0);

    // Random frames: encode, inject 0/1/2 distinct bit errors, predict from error count.
    for (int t = 0; t < 40; t++) begin
      d    = 11'($urandom);
      cw   = encode(d);
      nerr = $urandom_range(0, 2);
      p1   = $urandom_range(0, N - 1);
      do p2 = $urandom_range(0, N - 1); while (p2 == p1);
      if (nerr >= 1) cw[p1] = ~cw[p1];
      if (nerr == 2) cw[p2] = ~cw[p2];
      exp_d = (nerr == 2) ? raw_data(cw) : d;
      run_frame($sformatf("rand%0d_e%0d", t, nerr), cw, exp_d, nerr == 1, nerr == 2,
                $urandom_range(0, 24), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
